// File: rtl/dmem_resp.sv
// Data memory for the MEM stage: byte/half/word loads and stores, load extension,
// misalignment and illegal-code detection, and a response held until consumed.
module dmem_resp #(
    parameter int DATAWIDTH  = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DATAWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    input  logic [2:0]           req_funct3,
    input  logic [4:0]           req_rd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic [4:0]           rsp_rd,
    output logic                 rsp_err,
    output logic                 st_err
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NBYTES = DATAWIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Stores accept only B/H/W; loads additionally accept BU/HU.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off,
                                       input logic is_store);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~is_store;
            3'b101:  ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [NBYTES-1:0] store_mask(input logic [2:0] f3,
                                                     input logic [1:0] off);
        logic [NBYTES-1:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicating the datum across lanes lets the byte mask alone pick the target.
    function automatic logic [DATAWIDTH-1:0] store_lanes(input logic [DATAWIDTH-1:0] d,
                                                         input logic [2:0] f3);
        logic [DATAWIDTH-1:0] r;
        case (f3[1:0])
            2'b00:   r = {NBYTES{d[7:0]}};
            2'b01:   r = {(NBYTES/2){d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATAWIDTH-1:0] load_extend(input logic [DATAWIDTH-1:0] word,
                                                         input logic [2:0] f3,
                                                         input logic [1:0] off);
        logic [7:0]           b;
        logic [15:0]          h;
        logic [DATAWIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  r = {{(DATAWIDTH-8){b[7]}}, b};
            3'b001:  r = {{(DATAWIDTH-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(DATAWIDTH-8){1'b0}}, b};
            3'b101:  r = {{(DATAWIDTH-16){1'b0}}, h};
            default: r = {DATAWIDTH{1'b0}};
        endcase
        return r;
    endfunction

    state_t                  state_r;
    logic [DATAWIDTH-1:0]    mem_r [DEPTH];
    logic [DATAWIDTH-1:0]    rdata_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [2:0]              f3_r;
    logic [1:0]              off_r;
    logic [4:0]              rd_r;
    logic                    err_r;

    logic                    accept_s;
    logic                    legal_s;
    logic                    wr_en_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic [NBYTES-1:0]       mask_s;
    logic [DATAWIDTH-1:0]    lanes_s;
    logic                    addr_unused_s;

    // Request decode: acceptance, legality, RAM write strobe and lane data.
    always_comb begin
        req_ready     = (state_r == ST_IDLE);
        accept_s      = req_valid & (state_r == ST_IDLE);
        legal_s       = access_ok(req_funct3, req_addr[1:0], req_we);
        wr_en_s       = accept_s & req_we & legal_s & rst_n;
        idx_s         = req_addr[DEPTH_LOG2+1:2];
        mask_s        = store_mask(req_funct3, req_addr[1:0]);
        lanes_s       = store_lanes(req_wdata, req_funct3);
        addr_unused_s = ^req_addr[DATAWIDTH-1:DEPTH_LOG2+2];
    end

    // RAM array: byte-masked write at acceptance, synchronous read in RD1; no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_en_s && mask_s[i]) begin
                mem_r[idx_s][i*8 +: 8] <= lanes_s[i*8 +: 8];
            end
        end
        if (state_r == ST_RD1) begin
            rdata_r <= mem_r[idx_r];
        end
    end

    // Control FSM with registered response and store-error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= {DATAWIDTH{1'b0}};
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
            st_err    <= 1'b0;
            idx_r     <= {DEPTH_LOG2{1'b0}};
            f3_r      <= 3'd0;
            off_r     <= 2'd0;
            rd_r      <= 5'd0;
            err_r     <= 1'b0;
        end else begin
            st_err <= accept_s & req_we & ~legal_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !req_we) begin
                        state_r <= ST_RD1;
                        idx_r   <= idx_s;
                        f3_r    <= req_funct3;
                        off_r   <= req_addr[1:0];
                        rd_r    <= req_rd;
                        err_r   <= ~legal_s;
                    end
                end
                ST_RD1: state_r <= ST_RD2;
                ST_RD2: begin
                    state_r   <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= err_r ? {DATAWIDTH{1'b0}} : load_extend(rdata_r, f3_r, off_r);
                    rsp_rd    <= rd_r;
                    rsp_err   <= err_r;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed spec cases, backpressure, resets
// and randomized traffic against a byte-array memory model.
module tb_dmem_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        st_err;

    dmem_resp #(.DATAWIDTH(32), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .req_rd(req_rd), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_err(rsp_err), .st_err(st_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mb [0:4095];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        if (sz == 0) return 1'b0;
        if (st && f3 > 3'd2) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int     sz   = acc_size(f3);
        int     base = int'(a % 4096);
        longint v    = 0;
        if (!ref_legal(1'b0, f3, a)) return 32'd0;
        for (int i = sz - 1; i >= 0; i--) v = v * 256 + mb[base + i];
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v -= (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = acc_size(f3);
        if (ref_legal(1'b1, f3, a)) begin
            for (int i = 0; i < sz; i++) mb[int'(a % 4096) + i] = 8'((d >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            output logic se);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        req_funct3 = f3; req_rd = 5'd0;
        cyc();
        se = st_err;
        req_valid = 1'b0; req_we = 1'b0;
        ref_store(f3, a, d);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           output logic [31:0] d, output logic [4:0] ro, output logic e,
                           output int lat);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_funct3 = f3;
        req_rd = rd; req_wdata = $urandom;
        cyc();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        d = rsp_data; ro = rsp_rd; e = rsp_err;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_funct3 = 3'd0; req_rd = 5'd0; rsp_ready = 1'b1;
        repeat (3) cyc();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'd0) begin n_errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
        n_checks++; if (rsp_rd !== 5'd0) begin n_errors++; $display("FAIL rst_rsp_rd got %0d exp 0", rsp_rd); end
        n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
        n_checks++; if (st_err !== 1'b0) begin n_errors++; $display("FAIL rst_st_err got %b exp 0", st_err); end
        rst_n = 1'b1;
        cyc();
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] d; logic [4:0] ro; logic e, se; int lat;
        do_store(32'h10, 32'h8765_43A1, 3'b010, se);
        n_checks++; if (se !== 1'b0) begin n_errors++; $display("FAIL sw_st_err got %b exp 0", se); end
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready got %b exp 1", req_ready); end
        do_load(32'h10, 3'b000, 5'd5, d, ro, e, lat);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL lb_latency got %0d exp 3", lat); end
        n_checks++; if (d !== 32'hFFFF_FFA1) begin n_errors++; $display("FAIL lb_data got %h exp ffffffa1", d); end
        n_checks++; if (ro !== 5'd5) begin n_errors++; $display("FAIL lb_rd got %0d exp 5", ro); end
        n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL lb_err got %b exp 0", e); end
        do_load(32'h12, 3'b101, 5'd6, d, ro, e, lat);
        n_checks++; if (d !== 32'h0000_8765) begin n_errors++; $display("FAIL lhu_data got %h exp 00008765", d); end
        do_load(32'h12, 3'b001, 5'd7, d, ro, e, lat);
        n_checks++; if (d !== 32'hFFFF_8765) begin n_errors++; $display("FAIL lh_data got %h exp ffff8765", d); end
        do_load(32'h10, 3'b010, 5'd8, d, ro, e, lat);
        n_checks++; if (d !== 32'h8765_43A1) begin n_errors++; $display("FAIL lw_data got %h exp 876543a1", d); end
        do_store(32'h13, 32'h0000_0055, 3'b000, se);
        do_load(32'h10, 3'b010, 5'd9, d, ro, e, lat);
        n_checks++; if (d !== 32'h5565_43A1) begin n_errors++; $display("FAIL sb_merge got %h exp 556543a1", d); end
        do_load(32'h0000_1010, 3'b010, 5'd10, d, ro, e, lat);
        n_checks++; if (d !== 32'h5565_43A1) begin n_errors++; $display("FAIL addr_wrap got %h exp 556543a1", d); end
        do_load(32'h12, 3'b010, 5'd11, d, ro, e, lat);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_errors++; $display("FAIL lw_misalign got err=%b data=%h exp err=1 data=0", e, d); end
        n_checks++; if (lat !== 3 || ro !== 5'd11) begin n_errors++; $display("FAIL lw_misalign_timing got lat=%0d rd=%0d exp lat=3 rd=11", lat, ro); end
        do_load(32'h10, 3'b011, 5'd12, d, ro, e, lat);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_errors++; $display("FAIL illegal_f3_load got err=%b data=%h exp err=1 data=0", e, d); end
        do_store(32'h11, 32'hDEAD_BEEF, 3'b010, se);
        n_checks++; if (se !== 1'b1) begin n_errors++; $display("FAIL sw_misalign_st_err got %b exp 1", se); end
        cyc();
        n_checks++; if (st_err !== 1'b0) begin n_errors++; $display("FAIL st_err_pulse_width got %b exp 0", st_err); end
        do_store(32'h10, 32'hDEAD_BEEF, 3'b100, se);
        n_checks++; if (se !== 1'b1) begin n_errors++; $display("FAIL illegal_f3_store got %b exp 1", se); end
        do_load(32'h10, 3'b010, 5'd13, d, ro, e, lat);
        n_checks++; if (d !== 32'h5565_43A1) begin n_errors++; $display("FAIL rejected_store_nowrite got %h exp 556543a1", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; logic [4:0] r0; logic e0, se; int lat;
        logic [31:0] exp_w = ref_load(3'b010, 32'h10);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_rd = 5'd21;
        cyc();
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin cyc(); lat++; end
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL bp_latency got %0d exp 3", lat); end
        d0 = rsp_data; r0 = rsp_rd; e0 = rsp_err;
        n_checks++; if (d0 !== exp_w || r0 !== 5'd21 || e0 !== 1'b0) begin n_errors++; $display("FAIL bp_first got data=%h rd=%0d err=%b exp data=%h rd=21 err=0", d0, r0, e0, exp_w); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_w || rsp_rd !== 5'd21 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold cyc %0d got v=%b data=%h rd=%0d err=%b ready=%b exp v=1 data=%h rd=21 err=0 ready=0",
                         i, rsp_valid, rsp_data, rsp_rd, rsp_err, req_ready, exp_w);
            end
        end
        rsp_ready = 1'b1;
        cyc();
        req_valid = 1'b0; req_we = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release got v=%b ready=%b exp v=0 ready=1", rsp_valid, req_ready); end
        do_load(32'h10, 3'b010, 5'd22, d0, r0, e0, lat);
        n_checks++; if (d0 !== exp_w) begin n_errors++; $display("FAIL bp_no_accept_in_resp got %h exp %h", d0, exp_w); end
        se = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [4:0] ro; logic e, se; int lat; bit seen;
        do_store(32'h40, 32'hCAFE_1234, 3'b010, se);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010; req_rd = 5'd3;
        cyc();
        req_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_errors++; $display("FAIL midrst_no_response got rsp_valid=1 exp 0"); end
        // A store presented during reset must not reach the RAM.
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1111_2222; req_funct3 = 3'b010;
        cyc(); cyc();
        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        do_load(32'h40, 3'b010, 5'd4, d, ro, e, lat);
        n_checks++; if (d !== 32'hCAFE_1234) begin n_errors++; $display("FAIL rst_preserve_ignore got %h exp cafe1234", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a, w, exp_d; logic [4:0] ro; logic e, se; int lat;
        for (int k = 0; k < 8; k++) begin
            a = 32'h80 + 32'(k * 4);
            w = $urandom;
            do_store(a, w, 3'b010, se);
            do_store(a + 32'(k % 4), ~w, 3'b000, se);
            exp_d = ref_load(3'b010, a);
            do_load(a, 3'b010, 5'(k), d, ro, e, lat);
            n_checks++; if (d !== exp_d || e !== 1'b0) begin n_errors++; $display("FAIL b2b_st_ld k=%0d got %h err=%b exp %h err=0", k, d, e, exp_d); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, a, w, exp_d; logic [4:0] ro, rd; logic e, se; logic [2:0] f3; int lat; bit legal;
        for (int i = 0; i < 64; i++) do_store(32'(i * 4), $urandom, 3'b010, se);
        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                w = $urandom;
                legal = ref_legal(1'b1, f3, a);
                do_store(a, w, f3, se);
                n_checks++; if (se !== !legal) begin n_errors++; $display("FAIL rnd_store a=%h f3=%0d got st_err=%b exp %b", a, f3, se, !legal); end
            end else begin
                rd = 5'($urandom);
                legal = ref_legal(1'b0, f3, a);
                exp_d = ref_load(f3, a);
                do_load(a, f3, rd, d, ro, e, lat);
                n_checks++;
                if (lat !== 3 || d !== exp_d || ro !== rd || e !== !legal) begin
                    n_errors++;
                    $display("FAIL rnd_load a=%h f3=%0d got lat=%0d data=%h rd=%0d err=%b exp lat=3 data=%h rd=%0d err=%b",
                             a, f3, lat, d, ro, e, exp_d, rd, !legal);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DATAWIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of RAM depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  1  MEM-stage access request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  DATAWIDTH  byte address.
REQ-009 req_wdata  input  DATAWIDTH  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 req_rd  input  5  destination register tag for loads.
REQ-012 rsp_valid  output  1  load result available.
REQ-013 rsp_ready  input  1  writeback side consumes the result.
REQ-014 rsp_data  output  DATAWIDTH  extended load data.
REQ-015 rsp_rd  output  5  tag echoed from the accepted load.
REQ-016 rsp_err  output  1  accepted load was misaligned or had an illegal funct3.
REQ-017 st_err  output  1  one-cycle pulse for a rejected store.

Function
REQ-018 FSM states: IDLE, RD1, RD2, RESP; req_ready SHALL equal (state == IDLE).
REQ-019 Handshake: a request is accepted when req_valid & req_ready are both high; inputs are sampled only on that edge.
REQ-020 Word index = req_addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH words.
REQ-021 Legal store, accepted in cycle T: the RAM is written at edge T with the byte mask SB = 1 byte at addr[1:0], SH = 2 bytes at addr[1], SW = 4 bytes; the FSM stays in IDLE; no response is produced.
REQ-022 Legal load, accepted in cycle T: the FSM goes IDLE->RD1->RD2->RESP; rsp_valid SHALL rise at cycle T+3 (two cycles of RAM latency plus one registered output).
REQ-023 In RESP, rsp_valid, rsp_data, rsp_rd and rsp_err SHALL hold stable until rsp_ready=1; the FSM then returns to IDLE on that edge.
REQ-024 rsp_valid=1 with rsp_ready=1 SHALL NOT also accept a new request in the same cycle, because req_ready is 0 in RESP.
REQ-025 Load extension: B and H sign-extend; BU and HU zero-extend; W passes through. The selected byte or half is chosen by addr[1:0].
REQ-026 Misaligned accesses:
- H/HU/SH with addr[0]=1;
- W/SW with addr[1:0]!=0.
REQ-027 An illegal funct3 is any code other than those listed in REQ-010; store codes are 000, 001 and 010 only.
REQ-028 A misaligned or illegal load SHALL follow the same FSM path and timing, with rsp_data=0 and rsp_err=1.
REQ-029 A misaligned or illegal store SHALL NOT write the RAM, and st_err SHALL pulse high at cycle T+1.
REQ-030 A load issued immediately after a store to the same word SHALL return the new data; no bypass is needed, since the write completes at edge T.
REQ-031 The RAM array has no reset; its contents are undefined until written.

Reset
REQ-032 While rst_n=0 at a clock edge: state<=IDLE, rsp_valid<=0, rsp_data<=0, rsp_rd<=0, rsp_err<=0, st_err<=0; req_ready SHALL read 1 in the cycle after reset is released.
REQ-033 Reset asserted in RD1, RD2 or RESP SHALL abandon the pending load with no response; RAM contents are preserved.
REQ-034 A request presented while rst_n=0 SHALL be ignored, and no RAM write occurs.

Verification
REQ-035 SW addr 0x10 data 0x8765_43A1, then LB addr 0x10 rd 5 -> rsp_valid at T+3, rsp_data 0xFFFF_FFA1, rsp_rd 5, rsp_err 0.
REQ-036 Same word, LHU addr 0x12 -> 0x0000_8765; LH addr 0x12 -> 0xFFFF_8765; LW addr 0x10 -> 0x8765_43A1.
REQ-037 SB addr 0x13 data 0x55 over that word, then LW 0x10 -> 0x5565_43A1.
REQ-038 LW addr 0x0000_1010 with DEPTH_LOG2=10 -> returns word index 4 (address wrap).
REQ-039 LW addr 0x12 -> rsp_err 1, rsp_data 0. SW addr 0x11 -> st_err pulses at T+1 and the word is unchanged.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready 0 throughout. Assert rst_n=0 in RD2 -> rsp_valid never rises and req_ready=1 after release.
